// File: rtl/reg_ctrl_multi.sv
// Multi-register controller: DEPTH x DATA_W bank behind a sel/ready handshake
// with byte strobes, read-only masking, programmable wait states and error status.
module reg_ctrl_multi #(
    parameter int                DATA_W      = 16,
    parameter int                DEPTH       = 4,
    parameter int                ADDR_W      = 8,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0,
    parameter logic [DEPTH-1:0]  RO_MASK     = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sel,
    input  logic                     wr,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      wstrb,
    output logic [DATA_W-1:0]        rdata,
    output logic                     ready,
    output logic                     err,
    output logic [7:0]               err_cnt,
    output logic [DATA_W*DEPTH-1:0]  regs_flat
);

    localparam int              NB      = DATA_W / 8;
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [3:0]          cnt_r, cnt_s;
    logic                wr_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [NB-1:0]       wstrb_r;
    logic [DATA_W-1:0]   regs_r [DEPTH];
    logic [IDX_W-1:0]    idx_s;
    logic                addr_ok_s;
    logic                ro_s;
    logic                err_s;
    logic                commit_s;
    logic [DATA_W-1:0]   rd_val_s;
    logic [DATA_W-1:0]   rdata_r;
    logic                ready_r;
    logic                err_r;
    logic [7:0]          err_cnt_r;

    // Decode of the latched request; commit happens on the edge leaving the last wait cycle.
    always_comb begin
        idx_s     = addr_r[IDX_W-1:0];
        addr_ok_s = ({1'b0, addr_r} < DEPTH_A);
        commit_s  = (state_r == S_WAIT) && (cnt_r == 4'd0);
        if (addr_ok_s) begin
            ro_s     = RO_MASK[idx_s];
            rd_val_s = regs_r[idx_s];
        end else begin
            ro_s     = 1'b0;
            rd_val_s = '0;
        end
        err_s = !addr_ok_s || (wr_r && ro_s);
    end

    // Next-state logic. The wait counter starts at WAIT_CYCLES so that ready
    // lands WAIT_CYCLES+1 edges after sel is sampled, including the zero-wait case.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (sel) begin
                    state_s = S_WAIT;
                    cnt_s   = WAIT_LD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = S_RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            S_RESP:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State and wait-counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Request capture; later changes on the bus are ignored until the next IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            wstrb_r <= '0;
        end else if ((state_r == S_IDLE) && sel) begin
            wr_r    <= wr;
            addr_r  <= addr;
            wdata_r <= wdata;
            wstrb_r <= wstrb;
        end
    end

    // Register bank with per-byte-lane write commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= RESET_VAL;
            end
        end else if (commit_s && wr_r && !err_s) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb_r[b]) begin
                    regs_r[idx_s][b*8 +: 8] <= wdata_r[b*8 +: 8];
                end
            end
        end
    end

    // Response outputs, driven only in the RESP cycle, and saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r   <= 1'b0;
            err_r     <= 1'b0;
            rdata_r   <= '0;
            err_cnt_r <= 8'd0;
        end else begin
            ready_r <= commit_s;
            err_r   <= commit_s && err_s;
            rdata_r <= (commit_s && !wr_r) ? rd_val_s : '0;
            if (commit_s && err_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_r[g];
    end

    assign rdata   = rdata_r;
    assign ready   = ready_r;
    assign err     = err_r;
    assign err_cnt = err_cnt_r;

endmodule

// File: tb/tb_reg_ctrl_multi.sv
// Bench for reg_ctrl_multi: two instances (2 wait states with reg3 read-only, and
// zero wait states), a directed vector table, random traffic against a bank model.
module tb_reg_ctrl_multi;

    logic              clk;
    logic              rst;
    logic [1:0]        sel_v;
    logic [1:0]        wr_v;
    logic [1:0][7:0]   addr_v;
    logic [1:0][15:0]  wdata_v;
    logic [1:0][1:0]   wstrb_v;

    logic [15:0] rdata0, rdata1;
    logic        ready0, ready1, err0, err1;
    logic [7:0]  err_cnt0, err_cnt1;
    logic [63:0] flat0, flat1;

    logic [1:0][15:0] rdata_v;
    logic [1:0]       ready_v;
    logic [1:0]       err_v;
    logic [1:0][7:0]  err_cnt_v;
    logic [1:0][63:0] flat_v;

    assign rdata_v   = {rdata1, rdata0};
    assign ready_v   = {ready1, ready0};
    assign err_v     = {err1, err0};
    assign err_cnt_v = {err_cnt1, err_cnt0};
    assign flat_v    = {flat1, flat0};

    int checks   = 0;
    int failures = 0;

    // Reference model of both banks
    logic [15:0] mem [2][4];
    int          mcnt [2];
    logic [3:0]  ro_of [2];
    int          lat_of [2];

    reg_ctrl_multi #(.WAIT_CYCLES(2), .RO_MASK(4'b1000)) dut0 (
        .clk(clk), .rst(rst), .sel(sel_v[0]), .wr(wr_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .wstrb(wstrb_v[0]), .rdata(rdata0), .ready(ready0),
        .err(err0), .err_cnt(err_cnt0), .regs_flat(flat0)
    );

    reg_ctrl_multi #(.WAIT_CYCLES(0), .RO_MASK(4'b0000)) dut1 (
        .clk(clk), .rst(rst), .sel(sel_v[1]), .wr(wr_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .wstrb(wstrb_v[1]), .rdata(rdata1), .ready(ready1),
        .err(err1), .err_cnt(err_cnt1), .regs_flat(flat1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mflat(input int d);
        return {mem[d][3], mem[d][2], mem[d][1], mem[d][0]};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) mem[d][i] = 16'h0000;
            mcnt[d] = 0;
        end
    endtask

    task automatic model_txn(input int d, input logic w, input logic [7:0] a,
                             input logic [15:0] data, input logic [1:0] strb,
                             output logic [15:0] rd, output logic e);
        rd = 16'h0000;
        e  = 1'b0;
        if (a >= 8'd4) begin
            e = 1'b1;
        end else if (w) begin
            if (ro_of[d][a[1:0]]) e = 1'b1;
            else begin
                for (int b = 0; b < 2; b++)
                    if (strb[b]) mem[d][a[1:0]][b*8 +: 8] = data[b*8 +: 8];
            end
        end else begin
            rd = mem[d][a[1:0]];
        end
        if (e && mcnt[d] < 255) mcnt[d]++;
    endtask

    task automatic txn(input int d, input logic w, input logic [7:0] a,
                       input logic [15:0] data, input logic [1:0] strb,
                       output logic [15:0] rd, output logic e);
        bit seen;
        int lat;
        seen = 1'b0;
        lat  = 0;
        rd   = 16'h0000;
        e    = 1'b0;
        @(negedge clk);
        sel_v[d] = 1'b1; wr_v[d] = w; addr_v[d] = a; wdata_v[d] = data; wstrb_v[d] = strb;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (ready_v[d]) begin
                seen = 1'b1;
                lat  = k;
                rd   = rdata_v[d];
                e    = err_v[d];
                sel_v[d] = 1'b0;
                break;
            end
        end
        if (!seen) begin
            sel_v[d] = 1'b0;
            check("ready_timeout", 64'd0, 64'd1);
        end else begin
            check("latency", 64'(lat), 64'(lat_of[d]));
            @(posedge clk); #1;
            check("ready_one_cycle", 64'(ready_v[d]), 64'd0);
            check("rdata_idle_zero", 64'(rdata_v[d]), 64'd0);
            check("err_idle_zero", 64'(err_v[d]), 64'd0);
        end
    endtask

    task automatic run(input int d, input logic w, input logic [7:0] a,
                       input logic [15:0] data, input logic [1:0] strb,
                       output logic [15:0] rd, output logic e);
        logic [15:0] mrd;
        logic        me;
        txn(d, w, a, data, strb, rd, e);
        model_txn(d, w, a, data, strb, mrd, me);
        check("err", 64'(e), 64'(me));
        if (!w) check("rdata", 64'(rd), 64'(mrd));
        check("regs_flat", flat_v[d], mflat(d));
        check("err_cnt", 64'(err_cnt_v[d]), 64'(mcnt[d]));
    endtask

    task automatic reset_mid(input int d);
        bit seen;
        logic [15:0] rd;
        logic e;
        seen = 1'b0;
        @(negedge clk);
        sel_v[d] = 1'b1; wr_v[d] = 1'b1; addr_v[d] = 8'd0; wdata_v[d] = 16'h5A5A; wstrb_v[d] = 2'b11;
        @(posedge clk); #1; seen |= ready_v[d];
        @(negedge clk); rst = 1'b1; sel_v[d] = 1'b0;
        @(posedge clk); #1; seen |= ready_v[d];
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1; seen |= ready_v[d];
        end
        model_reset();
        check("rst_mid_no_ready", 64'(seen), 64'd0);
        check("rst_mid_regs", flat_v[d], 64'd0);
        check("rst_mid_err_cnt", 64'(err_cnt_v[d]), 64'd0);
        run(d, 1'b1, 8'd0, 16'hC0DE, 2'b11, rd, e);
        run(d, 1'b0, 8'd0, 16'h0000, 2'b00, rd, e);
        check("rst_mid_readback", 64'(rd), 64'h0000_0000_0000_C0DE);
    endtask

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [15:0] data;
        logic [1:0]  strb;
        logic        exp_err;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [15:0] rd;
        logic        e;
        bit          seen;

        ro_of[0]  = 4'b1000; ro_of[1]  = 4'b0000;
        lat_of[0] = 3;       lat_of[1] = 1;

        tbl[0]  = '{1'b1, 8'd1, 16'hBEEF, 2'b11, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 8'd1, 16'h0000, 2'b00, 1'b0, 16'hBEEF};
        tbl[2]  = '{1'b1, 8'd2, 16'hABCD, 2'b11, 1'b0, 16'h0000};
        tbl[3]  = '{1'b1, 8'd2, 16'h1234, 2'b01, 1'b0, 16'h0000};
        tbl[4]  = '{1'b0, 8'd2, 16'h0000, 2'b00, 1'b0, 16'hAB34};
        tbl[5]  = '{1'b1, 8'd2, 16'h5600, 2'b10, 1'b0, 16'h0000};
        tbl[6]  = '{1'b0, 8'd2, 16'h0000, 2'b00, 1'b0, 16'h5634};
        tbl[7]  = '{1'b0, 8'd7, 16'h0000, 2'b00, 1'b1, 16'h0000};
        tbl[8]  = '{1'b1, 8'd4, 16'h7777, 2'b11, 1'b1, 16'h0000};
        tbl[9]  = '{1'b1, 8'd3, 16'hFFFF, 2'b11, 1'b1, 16'h0000};
        tbl[10] = '{1'b0, 8'd3, 16'h0000, 2'b00, 1'b0, 16'h0000};
        tbl[11] = '{1'b1, 8'd1, 16'h9999, 2'b00, 1'b0, 16'h0000};
        tbl[12] = '{1'b0, 8'd1, 16'h0000, 2'b00, 1'b0, 16'hBEEF};
        tbl[13] = '{1'b0, 8'd255, 16'h0000, 2'b00, 1'b1, 16'h0000};

        rst = 1'b1;
        sel_v = 2'b00; wr_v = 2'b00; addr_v = '0; wdata_v = '0; wstrb_v = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1; seen |= (ready_v != 2'b00);
        end
        check("reset_regs0", flat_v[0], 64'd0);
        check("reset_regs1", flat_v[1], 64'd0);
        check("reset_err_cnt0", 64'(err_cnt_v[0]), 64'd0);
        check("reset_rdata0", 64'(rdata_v[0]), 64'd0);
        check("idle_no_ready", 64'(seen), 64'd0);

        for (int i = 0; i < 14; i++) begin
            run(0, tbl[i].w, tbl[i].a, tbl[i].data, tbl[i].strb, rd, e);
            check("tbl_err", 64'(e), 64'(tbl[i].exp_err));
            if (!tbl[i].w) check("tbl_rdata", 64'(rd), 64'(tbl[i].exp_rd));
        end
        check("tbl_err_cnt", 64'(err_cnt_v[0]), 64'd4);
        check("tbl_reg2", 64'(flat_v[0][47:32]), 64'h5634);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 120; i++) begin
                run(d, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 5)),
                    16'($urandom), 2'($urandom_range(0, 3)), rd, e);
            end
        end

        for (int i = 0; i < 300; i++) begin
            txn(1, 1'b0, 8'd9, 16'h0000, 2'b00, rd, e);
        end
        check("err_cnt_saturated", 64'(err_cnt_v[1]), 64'd255);
        mcnt[1] = 255;

        reset_mid(0);
        reset_mid(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
